// File: rtl/i2c_adc_target.sv
// I2C target returning a 12-bit ADC sample as two bytes; writes set the channel field.
// Optional macro I2C_ADC_TARGET_RAMP_EN replaces the sample input with an internal ramp counter.
module i2c_adc_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [11:0] sample,
    output logic [1:0]  channel,
    output logic        conv_req,
    output logic        busy
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_CMD       = 4'd3;
    localparam logic [3:0] S_CMD_ACK   = 4'd4;
    localparam logic [3:0] S_TX_MSB    = 4'd5;
    localparam logic [3:0] S_TX_LSB    = 4'd6;
    localparam logic [3:0] S_M_ACK     = 4'd7;
    localparam logic [3:0] S_WAIT_STOP = 4'd8;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic start_det;
    logic stop_det;
    logic scl_rise;
    logic scl_fall;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;

    logic [3:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic        byte_done_q, byte_done_d;
    logic        rw_q, rw_d;
    logic        lsb_q, lsb_d;
    logic [6:0]  tx_q, tx_d;
    logic        oe_q, oe_d;
    logic [1:0]  chan_q, chan_d;
    logic        busy_q, busy_d;
    logic [11:0] shadow_q, shadow_d;
    logic        conv_q, conv_d;
    logic        do_snap;
    logic [11:0] snap_val;

`ifdef I2C_ADC_TARGET_RAMP_EN
    logic [11:0] ramp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ramp_q <= '0;
        end else if (do_snap) begin
            ramp_q <= ramp_q + 12'd1;
        end
    end

    assign snap_val = ramp_q;
`else
    assign snap_val = sample;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        rw_d        = rw_q;
        lsb_d       = lsb_q;
        tx_d        = tx_q;
        oe_d        = oe_q;
        chan_d      = chan_q;
        busy_d      = busy_q;
        do_snap     = 1'b0;

        if (start_det) begin
            state_d     = S_ADDR;
            cnt_d       = 3'd0;
            oe_d        = 1'b0;
            byte_done_d = 1'b0;
        end else if (stop_det) begin
            state_d     = S_IDLE;
            cnt_d       = 3'd0;
            oe_d        = 1'b0;
            busy_d      = 1'b0;
            byte_done_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    // 8th rising edge: shift_q holds the address, SDA is R/W
                    if (scl_rise) begin
                        shift_d = {shift_q[5:0], sda_s};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (shift_q == DEV_ADDR) begin
                                byte_done_d = 1'b1;
                                rw_d        = sda_s;
                                busy_d      = 1'b1;
                            end else begin
                                state_d = S_WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end
                    end else if (scl_fall && byte_done_q) begin
                        state_d     = S_ADDR_ACK;
                        oe_d        = 1'b1;
                        byte_done_d = 1'b0;
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            do_snap = 1'b1;
                            state_d = S_TX_MSB;
                            lsb_d   = 1'b0;
                            // MSB byte is {4'b0000, data[11:8]}: first bit is always 0
                            tx_d    = {3'b000, snap_val[11:8]};
                            oe_d    = 1'b1;
                        end else begin
                            state_d = S_CMD;
                            oe_d    = 1'b0;
                        end
                    end
                end
                S_CMD: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[5:0], sda_s};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        state_d     = S_CMD_ACK;
                        oe_d        = 1'b1;
                        chan_d      = shift_q[5:4];
                        byte_done_d = 1'b0;
                    end
                end
                S_CMD_ACK: begin
                    if (scl_fall) begin
                        state_d = S_WAIT_STOP;
                        oe_d    = 1'b0;
                    end
                end
                S_TX_MSB, S_TX_LSB: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (byte_done_q) begin
                            state_d     = S_M_ACK;
                            oe_d        = 1'b0;
                            byte_done_d = 1'b0;
                            lsb_d       = (state_q == S_TX_LSB);
                        end else begin
                            oe_d = ~tx_q[6];
                            tx_d = {tx_q[5:0], 1'b0};
                        end
                    end
                end
                S_M_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = S_WAIT_STOP;
                        end else begin
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (lsb_q) begin
                            do_snap = 1'b1;
                            state_d = S_TX_MSB;
                            tx_d    = {3'b000, snap_val[11:8]};
                            oe_d    = 1'b1;
                        end else begin
                            state_d = S_TX_LSB;
                            tx_d    = shadow_q[6:0];
                            oe_d    = ~shadow_q[7];
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        shadow_d = do_snap ? snap_val : shadow_q;
        conv_d   = do_snap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            rw_q        <= 1'b0;
            lsb_q       <= 1'b0;
            tx_q        <= '0;
            oe_q        <= 1'b0;
            chan_q      <= 2'd0;
            busy_q      <= 1'b0;
            shadow_q    <= '0;
            conv_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            rw_q        <= rw_d;
            lsb_q       <= lsb_d;
            tx_q        <= tx_d;
            oe_q        <= oe_d;
            chan_q      <= chan_d;
            busy_q      <= busy_d;
            shadow_q    <= shadow_d;
            conv_q      <= conv_d;
        end
    end

    assign sda_oe   = oe_q;
    assign channel  = chan_q;
    assign conv_req = conv_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_adc_target.sv
// Bit-banged I2C master against i2c_adc_target; read data checked through an expected-byte queue.
module tb_i2c_adc_target;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [11:0] sample = 12'h000;
    logic        sda_oe;
    logic [1:0]  channel;
    logic        conv_req;
    logic        busy;
    wire         sda_line = sda_m & ~sda_oe;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    int          conv_cnt = 0;
    int          conv_wide = 0;
    logic        conv_prev = 1'b0;
    logic        oe_seen = 1'b0;
`ifdef I2C_ADC_TARGET_RAMP_EN
    logic [11:0] ramp_model = 12'd0;
`endif

    always #5 clk = ~clk;

    i2c_adc_target #(.DEV_ADDR(7'h48), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .sample   (sample),
        .channel  (channel),
        .conv_req (conv_req),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (conv_req) conv_cnt++;
        if (conv_req && conv_prev) conv_wide++;
        conv_prev = conv_req;
        if (sda_oe) oe_seen = 1'b1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic wq();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic rd);
        wq(); sda_m = b;
        wq(); scl_m = 1'b1;
        wq(); rd = sda_line;
        wq(); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        wq(); sda_m = 1'b1;
        wq(); scl_m = 1'b1;
        wq(); sda_m = 1'b0;
        wq(); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wq(); sda_m = 1'b0;
        wq(); scl_m = 1'b1;
        wq(); sda_m = 1'b1;
        wq(); wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(b[i], r);
        send_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, r);
            b[i] = r;
        end
        send_bit(~m_ack, r);
    endtask

    task automatic note_reset();
`ifdef I2C_ADC_TARGET_RAMP_EN
        ramp_model = 12'd0;
`endif
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        note_reset();
    endtask

    // Expected bytes of one frame, given the sample that will be snapshotted
    task automatic push_frame(input logic [11:0] s);
        logic [11:0] v;
`ifdef I2C_ADC_TARGET_RAMP_EN
        v = ramp_model;
        ramp_model = ramp_model + 12'd1;
`else
        v = s;
`endif
        exp_q.push_back({4'h0, v[11:8]});
        exp_q.push_back(v[7:0]);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (channel !== 2'd0) begin n_fail++; $display("FAIL reset_channel: got %0d expected 0", channel); end
        n_checks++;
        if (conv_req !== 1'b0) begin n_fail++; $display("FAIL reset_conv_req: got %b expected 0", conv_req); end
        rst = 1'b1;
        note_reset();
        wq();
    endtask

    task automatic test_write();
        logic [7:0] cmds[3] = '{8'h84, 8'hB4, 8'hA0};
        logic [1:0] chans[3] = '{2'd0, 2'd3, 2'd2};
        logic ack;
        for (int k = 0; k < 3; k++) begin
            i2c_start();
            write_byte(8'h90, ack);
            n_checks++;
            if (ack !== 1'b1) begin n_fail++; $display("FAIL write_addr_ack[%0d]: got %b expected 1", k, ack); end
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy[%0d]: got %b expected 1", k, busy); end
            write_byte(cmds[k], ack);
            n_checks++;
            if (ack !== 1'b1) begin n_fail++; $display("FAIL write_cmd_ack[%0d]: got %b expected 1", k, ack); end
            i2c_stop();
            n_checks++;
            if (channel !== chans[k]) begin n_fail++; $display("FAIL write_channel[%0d]: got %0d expected %0d", k, channel, chans[k]); end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_stop[%0d]: got %b expected 0", k, busy); end
        end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] got, e;
        int c0;
        sample = 12'hA5C;
        push_frame(sample);
        c0 = conv_cnt;
        i2c_start();
        write_byte(8'h91, ack);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack: got %b expected 1", ack); end
        read_byte(1'b1, got);
        sample = 12'h000;
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL read_msb: got %h expected %h", got, e); end
        read_byte(1'b0, got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL read_lsb: got %h expected %h", got, e); end
        i2c_stop();
        n_checks++;
        if (conv_cnt - c0 !== 1) begin n_fail++; $display("FAIL read_conv_pulses: got %0d expected 1", conv_cnt - c0); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_mismatch();
        logic ack;
        int c0;
        c0 = conv_cnt;
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'h92, ack);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL mismatch_ack: got %b expected 0", ack); end
        write_byte(8'h55, ack);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy: got %b expected 0", busy); end
        i2c_stop();
        n_checks++;
        if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL mismatch_sda_oe: got %b expected 0", oe_seen); end
        n_checks++;
        if (conv_cnt !== c0) begin n_fail++; $display("FAIL mismatch_conv: got %0d expected %0d", conv_cnt, c0); end
    endtask

    task automatic test_stream();
        logic [11:0] vals[4] = '{12'h123, 12'h456, 12'h789, 12'h000};
        logic ack;
        logic [7:0] got, e;
        int c0, w0;
        pulse_reset();
        wq();
        c0 = conv_cnt;
        w0 = conv_wide;
        sample = vals[0];
        i2c_start();
        write_byte(8'h91, ack);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL stream_addr_ack: got %b expected 1", ack); end
        for (int f = 0; f < 3; f++) begin
            push_frame(vals[f]);
            read_byte(1'b1, got);
            sample = vals[f+1];
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL stream_msb[%0d]: got %h expected %h", f, got, e); end
            read_byte(f < 2, got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL stream_lsb[%0d]: got %h expected %h", f, got, e); end
        end
        i2c_stop();
        n_checks++;
        if (conv_cnt - c0 !== 3) begin n_fail++; $display("FAIL stream_conv_pulses: got %0d expected 3", conv_cnt - c0); end
        n_checks++;
        if (conv_wide !== w0) begin n_fail++; $display("FAIL stream_conv_width: got %0d wide pulses expected 0", conv_wide - w0); end
    endtask

    task automatic test_restart();
        logic ack, r;
        logic [7:0] got, e;
        int c0;
        c0 = conv_cnt;
        sample = 12'hA5C;
        push_frame(sample);
        i2c_start();
        write_byte(8'h91, ack);
        got = 8'h00;
`ifdef I2C_ADC_TARGET_RAMP_EN
        // Ramp values keep bit 3 of the MSB byte low, so restart from the master-ACK slot
        for (int i = 7; i >= 0; i--) begin send_bit(1'b1, r); got[i] = r; end
        e = exp_q.pop_front();
`else
        for (int i = 7; i >= 4; i--) begin send_bit(1'b1, r); got[i] = r; end
        e = exp_q.pop_front() & 8'hF0;
`endif
        void'(exp_q.pop_front());
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL restart_partial_msb: got %h expected %h", got, e); end
        sample = 12'h3C7;
        push_frame(sample);
        i2c_start();
        write_byte(8'h91, ack);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL restart_addr_ack: got %b expected 1", ack); end
        read_byte(1'b1, got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL restart_msb: got %h expected %h", got, e); end
        read_byte(1'b0, got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL restart_lsb: got %h expected %h", got, e); end
        i2c_stop();
        n_checks++;
        if (conv_cnt - c0 !== 2) begin n_fail++; $display("FAIL restart_conv_pulses: got %0d expected 2", conv_cnt - c0); end
    endtask

    task automatic test_reset_mid();
        logic ack;
        logic [7:0] got, e;
        sample = 12'hA5C;
        push_frame(sample);
        i2c_start();
        write_byte(8'h91, ack);
        read_byte(1'b1, got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL midrst_msb: got %h expected %h", got, e); end
        e = exp_q.pop_front();
        wq();
        n_checks++;
        if (sda_oe !== ~e[7]) begin n_fail++; $display("FAIL midrst_lsb_drive: got %b expected %b", sda_oe, ~e[7]); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_sda_release: got %b expected 0", sda_oe); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        note_reset();
        oe_seen = 1'b0;
        read_byte(1'b0, got);
        write_byte(8'h90, ack);
        n_checks++;
        if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_response: got sda_oe seen %b expected 0", oe_seen); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        i2c_stop();
        i2c_start();
        write_byte(8'h90, ack);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL midrst_new_start_ack: got %b expected 1", ack); end
        i2c_stop();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_restart();
        test_stream();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_adc_target.md
I2C_ADC_TARGET -- requirements
Module: i2c_adc_target

Interface
REQ-001 SHALL have parameter: DEV_ADDR, 7'h48, 7-bit I2C target address.
REQ-002 SHALL have parameter: SYNC_STAGES, 2, number of SCL/SDA input synchroniser flops (min 2).
REQ-003 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: scl_in  input  1  bus SCL level, asynchronous to clk.
REQ-006 SHALL have port: sda_in  input  1  bus SDA level, asynchronous to clk.
REQ-007 SHALL have port: sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain).
REQ-008 SHALL have port: sample  input  12  current conversion result.
REQ-009 SHALL have port: channel  output  2  channel field (cmd bits [5:4]) from last written command byte.
REQ-010 SHALL have port: conv_req  output  1  one-cycle pulse on each sample snapshot.
REQ-011 SHALL have port: busy  output  1  high from valid address match until STOP/mismatch.

Function
REQ-012 SHALL pass scl_in/sda_in through SYNC_STAGES flops, then detect edges on the synchronised signals.
REQ-013 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-014 SHALL sample SDA only on SCL rising edge, and SHALL change sda_oe only on SCL falling edge.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX_MSB, TX_LSB, M_ACK, WAIT_STOP.
REQ-016 SHALL go IDLE->ADDR on START; ADDR shifts 8 bits MSB-first (7 address bits + R/W).
REQ-017 SHALL, when the address matches DEV_ADDR, go to ADDR_ACK and drive ACK (sda_oe=1) for one SCL bit.
REQ-018 SHALL, when the address does not match, go to WAIT_STOP with sda_oe held 0.
REQ-019 SHALL, for W, go ADDR_ACK->CMD: shift 8 bits, ACK in CMD_ACK, load channel, then WAIT_STOP.
REQ-020 SHALL, for R, snapshot sample into a 12-bit shadow register and pulse conv_req for 1 clk at the ADDR_ACK falling SCL edge.
REQ-021 SHALL transmit TX_MSB = {4'b0000, shadow[11:8]} then TX_LSB = shadow[7:0], MSB-first.
REQ-022 SHALL release SDA for the master ACK bit after each byte (M_ACK).
REQ-023 SHALL, on master ACK after MSB, proceed to TX_LSB.
REQ-024 SHALL, on master ACK after LSB, take a new snapshot (conv_req pulse) and return to TX_MSB (streaming).
REQ-025 SHALL, on master NACK after any byte, release SDA and go to WAIT_STOP.
REQ-026 SHALL, on STOP in any state, go to IDLE, set sda_oe=0 and busy=0 within 1 clk of detection.
REQ-027 SHALL, on repeated START in any state, go to ADDR, clear the bit counter and set sda_oe=0; START takes priority over a same-cycle SCL edge.
REQ-028 SHALL use a 3-bit bit counter that wraps 7->0 at each byte boundary; no other counters may overflow.
REQ-029 SHALL NOT stretch the clock (never drive SCL).

Reset
REQ-030 SHALL, on rst=0, asynchronously set: state=IDLE, sda_oe=0, channel=0, conv_req=0, busy=0, shadow=0, and all synchronisers to 1 (idle bus).
REQ-031 SHALL, when rst is asserted mid-transfer, release SDA immediately and ignore the remainder of the transaction until the next START after reset release.

Configuration
REQ-032 SHALL, with macro I2C_ADC_TARGET_RAMP_EN defined, load the shadow register from an internal 12-bit ramp counter (reset 0) instead of sample; the counter increments by 1 per snapshot and wraps 4095->0.
REQ-033 SHALL, with I2C_ADC_TARGET_RAMP_EN undefined, contain no ramp logic and take the shadow from sample.

Verification
REQ-034 SHALL cover: START, 0x90, cmd 0x84, STOP -> two ACKs, channel=2'b00, busy low after STOP.
REQ-035 SHALL cover: sample=12'hA5C; START, 0x91, master ACK, NACK, STOP -> bytes 0x0A, 0x5C; one conv_req pulse.
REQ-036 SHALL cover: START, 0x92 (address mismatch) -> sda_oe stays 0 throughout; state=WAIT_STOP until STOP.
REQ-037 SHALL cover: read with ACK after LSB, three 2-byte frames, RAMP_EN defined -> data 0x000, 0x001, 0x002; three conv_req pulses.
REQ-038 SHALL cover: repeated START during TX_MSB bit 3, then 0x91 -> clean restart, ACK, new snapshot returned.
REQ-039 SHALL cover: rst asserted while sda_oe=1 in TX_LSB -> sda_oe=0 same cycle; after release, no response until a new START.
